// File: rtl/seg_bus_decoder.sv
// Display-bus receiver: decodes strobed 7-segment digits into an HH:MM:SS frame and publishes 24h BCD time.
// Optional colon period measurement is compiled in with `define COLON_PERIOD_EN.
module seg_bus_decoder #(
  parameter int FRAME_TIMEOUT = 64,
  parameter int PERIOD_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg7,
  input  logic [5:0]          le,
  input  logic                pm,
  input  logic                colon,
  input  logic                mode12,
  output logic [7:0]          hours_bcd,
  output logic [7:0]          min_bcd,
  output logic [7:0]          sec_bcd,
  output logic                time_valid,
  output logic                sec_tick,
  output logic                seg_err,
  output logic                range_err,
  output logic                timeout_err,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] colon_period,
  output logic                period_valid,
  output logic [1:0]          fsm_state     // 0 = IDLE, 1 = COLLECT, 2 = COMMIT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
  localparam int         TW        = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_TIMEOUT - 1);

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = {1'b1, 4'd0};
      7'b0110000: decode = {1'b1, 4'd1};
      7'b1101101: decode = {1'b1, 4'd2};
      7'b1111001: decode = {1'b1, 4'd3};
      7'b0110011: decode = {1'b1, 4'd4};
      7'b1011011: decode = {1'b1, 4'd5};
      7'b1011111: decode = {1'b1, 4'd6};
      7'b1110000: decode = {1'b1, 4'd7};
      7'b1111111: decode = {1'b1, 4'd8};
      7'b1111011: decode = {1'b1, 4'd9};
      default:    decode = 5'd0;
    endcase
  endfunction

  logic [1:0]    state;
  logic [5:0]    mask;
  logic [TW-1:0] tcnt;
  logic          pm_q;
  logic [3:0]    digit [6];

  logic [4:0] dec;
  logic       strobe_ok, strobe_bad, le_multi;
  logic       timeout_fire, commit_pass, range_fail, frame_ok, hour_ok;
  logic [6:0] hour_bin, hour24;
  logic [7:0] hours_next;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign dec        = decode(seg7);
  assign le_multi   = |(le & (le - 6'd1));
  assign strobe_ok  = (|le) && !le_multi && dec[4];
  assign strobe_bad = (|le) && !strobe_ok;
  assign fsm_state  = state;

  // The timeout only runs while a partial frame is pending; a full mask always proceeds to COMMIT.
  assign timeout_fire = (state == S_COLLECT) && (mask != 6'h3f) && !strobe_ok && (tcnt == T_LAST);

  assign hour_bin = 7'(digit[0]) * 7'd10 + 7'(digit[1]);
  assign hour_ok  = mode12 ? (hour_bin >= 7'd1 && hour_bin <= 7'd12)
                           : (digit[0] <= 4'd2 && digit[1] <= 4'd9 && hour_bin <= 7'd23);
  assign frame_ok    = hour_ok && (digit[2] <= 4'd5) && (digit[4] <= 4'd5);
  assign commit_pass = (state == S_COMMIT) && frame_ok;
  assign range_fail  = (state == S_COMMIT) && !frame_ok;

  always_comb begin
    hour24 = hour_bin;
    if (mode12) begin
      if (hour_bin == 7'd12) hour24 = pm_q ? 7'd12 : 7'd0;
      else if (pm_q)         hour24 = hour_bin + 7'd12;
    end
    if (hour24 >= 7'd20)      hours_next = {4'd2, 4'(hour24 - 7'd20)};
    else if (hour24 >= 7'd10) hours_next = {4'd1, 4'(hour24 - 7'd10)};
    else                      hours_next = {4'd0, hour24[3:0]};
  end

  // time_valid is a single-cycle strobe with no back-pressure: a consumer must capture the
  // BCD outputs in the cycle the pulse is high; they hold until the next passing frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mask        <= 6'd0;
      tcnt        <= '0;
      pm_q        <= 1'b0;
      hours_bcd   <= 8'd0;
      min_bcd     <= 8'd0;
      sec_bcd     <= 8'd0;
      time_valid  <= 1'b0;
      sec_tick    <= 1'b0;
      seg_err     <= 1'b0;
      range_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 6; i++) digit[i] <= 4'd0;
    end else begin
      seg_err     <= strobe_bad;
      range_err   <= range_fail;
      timeout_err <= timeout_fire;
      time_valid  <= commit_pass;
      sec_tick    <= commit_pass && ({digit[4], digit[5]} != sec_bcd);
      if (commit_pass) begin
        hours_bcd <= hours_next;
        min_bcd   <= {digit[2], digit[3]};
        sec_bcd   <= {digit[4], digit[5]};
      end
      if (strobe_ok) begin
        for (int i = 0; i < 6; i++) if (le[i]) digit[i] <= dec[3:0];
        if (le[1]) pm_q <= pm;
      end
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (strobe_ok) begin
            mask  <= le;
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (strobe_ok) begin
            mask <= mask | le;
            tcnt <= '0;
          end else if (mask != 6'h3f) begin
            tcnt <= timeout_fire ? '0 : tcnt + 1'b1;
          end
          if (mask == 6'h3f) begin
            state <= S_COMMIT;
          end else if (timeout_fire) begin
            mask  <= 6'd0;
            state <= S_IDLE;
          end
        end
        S_COMMIT: begin
          tcnt <= '0;
          // A strobe arriving while the old frame commits starts the next frame.
          if (strobe_ok) begin
            mask  <= le;
            state <= S_COLLECT;
          end else begin
            mask  <= 6'd0;
            state <= S_IDLE;
          end
        end
        default: begin
          mask  <= 6'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign err_inc = 2'(strobe_bad) + 2'(range_fail) + 2'(timeout_fire);
  assign err_sum = {1'b0, err_count} + 9'(err_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_count <= 8'd0;
    else if (err_sum > 9'd255) err_count <= 8'd255;
    else                     err_count <= err_sum[7:0];
  end

`ifdef COLON_PERIOD_EN
  logic                col_s1, col_s2, col_d, first_seen, col_edge;
  logic [PERIOD_W-1:0] pcnt;

  assign col_edge = col_s2 ^ col_d;

  // pcnt restarts at 1 on an edge so that it equals the clock distance when the next edge arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1       <= 1'b0;
      col_s2       <= 1'b0;
      col_d        <= 1'b0;
      first_seen   <= 1'b0;
      pcnt         <= '0;
      colon_period <= '0;
      period_valid <= 1'b0;
    end else begin
      col_s1       <= colon;
      col_s2       <= col_s1;
      col_d        <= col_s2;
      period_valid <= 1'b0;
      if (col_edge) begin
        pcnt       <= PERIOD_W'(1);
        first_seen <= 1'b1;
        if (first_seen) begin
          colon_period <= pcnt;
          period_valid <= 1'b1;
        end
      end else if (pcnt != '1) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
`else
  logic unused_colon;
  assign unused_colon = colon;
  assign colon_period = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg_bus_decoder.sv
// Bench for seg_bus_decoder: directed frame table, hand sequences for multi-cycle corners,
// and randomized bus traffic checked every cycle against a digit-level reference model.
module tb_seg_bus_decoder;

  localparam int FT = 64;
  localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg7;
  logic [5:0] le;
  logic       pm, colon, mode12;
  logic [7:0] hours_bcd, min_bcd, sec_bcd, err_count;
  logic       time_valid, sec_tick, seg_err, range_err, timeout_err, period_valid;
  logic [7:0] colon_period;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_bus_decoder #(.FRAME_TIMEOUT(FT), .PERIOD_W(8)) dut (
    .clk(clk), .rst(rst), .seg7(seg7), .le(le), .pm(pm), .colon(colon), .mode12(mode12),
    .hours_bcd(hours_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .time_valid(time_valid),
    .sec_tick(sec_tick), .seg_err(seg_err), .range_err(range_err), .timeout_err(timeout_err),
    .err_count(err_count), .colon_period(colon_period), .period_valid(period_valid),
    .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (digit/integer level) ----------------
  int m_d [6];
  bit m_have [6];
  bit m_pm, m_commit;
  int m_idle;
  int e_h, e_m, e_s, e_cnt;
  bit e_tv, e_tick, e_seg, e_rng, e_to;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin m_d[i] = 0; m_have[i] = 0; end
    m_pm = 0; m_commit = 0; m_idle = 0;
    e_h = 0; e_m = 0; e_s = 0; e_cnt = 0;
    e_tv = 0; e_tick = 0; e_seg = 0; e_rng = 0; e_to = 0;
  endtask

  task automatic model_step();
    int ones, idx, val, h, mi, s;
    bit hit, was_full, any_have, committing, ok;
    ones = $countones(le);
    idx = -1; val = -1;
    for (int i = 0; i < 6; i++) if (le[i]) idx = i;
    for (int v = 0; v < 10; v++) if (seg7 == PAT[v]) val = v;
    hit = (ones == 1) && (val >= 0);
    was_full = 1; any_have = 0;
    for (int i = 0; i < 6; i++) begin
      if (!m_have[i]) was_full = 0;
      if (m_have[i]) any_have = 1;
    end
    committing = m_commit;
    e_tv = 0; e_tick = 0; e_rng = 0; e_to = 0;
    e_seg = (ones > 0) && !hit;
    if (committing) begin
      h  = 10 * m_d[0] + m_d[1];
      mi = 10 * m_d[2] + m_d[3];
      s  = 10 * m_d[4] + m_d[5];
      ok = mode12 ? (h >= 1 && h <= 12) : (m_d[0] <= 2 && h <= 23);
      ok = ok && m_d[2] <= 5 && m_d[4] <= 5;
      if (ok) begin
        e_tick = (s != e_s);
        e_h = mode12 ? (h % 12) + (m_pm ? 12 : 0) : h;
        e_m = mi; e_s = s; e_tv = 1;
      end else begin
        e_rng = 1;
      end
      for (int i = 0; i < 6; i++) m_have[i] = 0;
      m_idle = 0;
    end else if (any_have && !was_full && !hit) begin
      if (m_idle == FT - 1) begin
        for (int i = 0; i < 6; i++) m_have[i] = 0;
        e_to = 1; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (hit) begin
      m_d[idx] = val; m_have[idx] = 1; m_idle = 0;
      if (idx == 1) m_pm = pm;
    end
    m_commit = was_full && !committing;
    e_cnt = e_cnt + int'(e_seg) + int'(e_rng) + int'(e_to);
    if (e_cnt > 255) e_cnt = 255;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (hours_bcd !== to_bcd(e_h) || min_bcd !== to_bcd(e_m) || sec_bcd !== to_bcd(e_s) ||
          time_valid !== e_tv || sec_tick !== e_tick || seg_err !== e_seg ||
          range_err !== e_rng || timeout_err !== e_to || err_count !== 8'(e_cnt)) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got h=%h m=%h s=%h tv=%b tick=%b seg=%b rng=%b to=%b cnt=%0d, expected h=%h m=%h s=%h tv=%b tick=%b seg=%b rng=%b to=%b cnt=%0d",
                 $time, hours_bcd, min_bcd, sec_bcd, time_valid, sec_tick, seg_err, range_err,
                 timeout_err, err_count, to_bcd(e_h), to_bcd(e_m), to_bcd(e_s), e_tv, e_tick,
                 e_seg, e_rng, e_to, e_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int idx, input logic [6:0] p);
    le = 6'(1 << idx);
    seg7 = p;
    cyc();
    le = 6'd0;
  endtask

  task automatic send_frame(input logic [23:0] dig);
    for (int k = 0; k < 6; k++) begin
      le = 6'(1 << k);
      seg7 = PAT[dig[23-4*k -: 4]];
      cyc();
    end
    le = 6'd0;
  endtask

  int pv_seen;
  logic [7:0] last_period;

  task automatic colon_run(input int period, input int n);
    for (int t = 0; t < n; t++) begin
      colon = ~colon;
      repeat (period) begin
        cyc();
        if (period_valid) begin
          pv_seen++;
          last_period = colon_period;
        end
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [23:0] dig;
    bit          pm;
    bit          m12;
    bit          tv;
    bit          rng;
    logic [7:0]  h, m, s;
    bit          tick;
  } vec_t;

  vec_t vec [11];
  bit   early;

  initial begin
    vec[0]  = '{"f134507",   24'h134507, 0, 0, 1, 0, 8'h13, 8'h45, 8'h07, 1};
    vec[1]  = '{"f12am",     24'h120000, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1};
    vec[2]  = '{"f12pm",     24'h120000, 1, 1, 1, 0, 8'h12, 8'h00, 8'h00, 0};
    vec[3]  = '{"f01pm",     24'h010000, 1, 1, 1, 0, 8'h13, 8'h00, 8'h00, 0};
    vec[4]  = '{"f_mt6",     24'h106000, 0, 0, 0, 1, 8'h13, 8'h00, 8'h00, 0};
    vec[5]  = '{"f235959",   24'h235959, 0, 0, 1, 0, 8'h23, 8'h59, 8'h59, 1};
    vec[6]  = '{"f_h24",     24'h240000, 0, 0, 0, 1, 8'h23, 8'h59, 8'h59, 0};
    vec[7]  = '{"f_h0_12h",  24'h000000, 0, 1, 0, 1, 8'h23, 8'h59, 8'h59, 0};
    vec[8]  = '{"f11pm",     24'h113000, 1, 1, 1, 0, 8'h23, 8'h30, 8'h00, 1};
    vec[9]  = '{"f000000",   24'h000000, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0};
    vec[10] = '{"f_st6",     24'h015960, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0};

    // clock/reset
    rst = 1'b1; seg7 = 7'd0; le = 6'd0; pm = 1'b0; colon = 1'b0; mode12 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hours", hours_bcd, 8'h00);
    check("reset_min", min_bcd, 8'h00);
    check("reset_sec", sec_bcd, 8'h00);
    check("reset_err_count", err_count, 8'd0);
    check("reset_time_valid", time_valid, 1'b0);
    check("reset_state", fsm_state, 2'd0);
    rst = 1'b0;
    cyc();

    // invalid pattern, then le collision
    strobe(0, 7'b0000001);
    check("bad_pattern_seg_err", seg_err, 1'b1);
    check("bad_pattern_err_count", err_count, 8'd1);
    check("bad_pattern_state", fsm_state, 2'd0);
    cyc();
    check("seg_err_one_cycle", seg_err, 1'b0);
    le = 6'b000011; seg7 = PAT[1];
    cyc();
    le = 6'd0;
    check("collision_seg_err", seg_err, 1'b1);
    check("collision_err_count", err_count, 8'd2);
    repeat (3) cyc();
    check("no_commit_after_errors", time_valid, 1'b0);

    // frame table
    for (int i = 0; i < 11; i++) begin
      pm = vec[i].pm; mode12 = vec[i].m12;
      send_frame(vec[i].dig);
      cyc();
      check({vec[i].name, "_early_tv"}, time_valid, 1'b0);
      cyc();
      check({vec[i].name, "_tv"}, time_valid, vec[i].tv);
      check({vec[i].name, "_range_err"}, range_err, vec[i].rng);
      check({vec[i].name, "_hours"}, hours_bcd, vec[i].h);
      check({vec[i].name, "_min"}, min_bcd, vec[i].m);
      check({vec[i].name, "_sec"}, sec_bcd, vec[i].s);
      check({vec[i].name, "_sec_tick"}, sec_tick, vec[i].tick);
      cyc();
    end

    // partial frame timeout on the 64th idle clock
    pm = 1'b0; mode12 = 1'b0;
    strobe(0, PAT[1]);
    strobe(1, PAT[2]);
    early = 0;
    repeat (FT - 1) begin
      cyc();
      if (timeout_err) early = 1;
    end
    check("timeout_not_early", early, 1'b0);
    cyc();
    check("timeout_err_pulse", timeout_err, 1'b1);
    check("timeout_state_idle", fsm_state, 2'd0);
    send_frame(24'h123456);
    repeat (2) cyc();
    check("after_timeout_tv", time_valid, 1'b1);
    check("after_timeout_hours", hours_bcd, 8'h12);
    check("after_timeout_sec", sec_bcd, 8'h56);

    // strobe sampled during COMMIT starts the next frame
    send_frame(24'h081530);
    cyc();
    strobe(0, PAT[2]);
    check("overlap_a_tv", time_valid, 1'b1);
    check("overlap_a_hours", hours_bcd, 8'h08);
    check("overlap_a_min", min_bcd, 8'h15);
    check("overlap_a_sec", sec_bcd, 8'h30);
    for (int k = 1; k < 6; k++) strobe(k, PAT[(k == 1) ? 0 : (k == 2) ? 4 : (k == 3) ? 1 : (k == 4) ? 0 : 5]);
    repeat (2) cyc();
    check("overlap_b_tv", time_valid, 1'b1);
    check("overlap_b_hours", hours_bcd, 8'h20);
    check("overlap_b_min", min_bcd, 8'h41);
    check("overlap_b_sec", sec_bcd, 8'h05);

    // asynchronous reset mid-frame
    strobe(0, PAT[1]); strobe(1, PAT[1]); strobe(2, PAT[1]);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset_hours", hours_bcd, 8'h00);
    check("midframe_reset_err_count", err_count, 8'd0);
    check("midframe_reset_state", fsm_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // randomized bus traffic
    for (int n = 0; n < 3000; n++) begin
      int r, idx, v;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 7) == 0) mode12 = ~mode12;
      pm = 1'($urandom_range(0, 1));
      if (r < 60) begin
        idx = $urandom_range(0, 5);
        case (idx)
          0:       v = $urandom_range(0, 2);
          2, 4:    v = $urandom_range(0, 6);
          default: v = $urandom_range(0, 9);
        endcase
        le = 6'(1 << idx);
        seg7 = PAT[v];
        cyc();
      end else if (r < 64) begin
        le = 6'(1 << $urandom_range(0, 5));
        seg7 = 7'($urandom);
        cyc();
      end else if (r < 67) begin
        le = 6'($urandom_range(1, 63));
        seg7 = PAT[$urandom_range(0, 9)];
        cyc();
      end else if (r == 67) begin
        le = 6'd0;
        repeat ($urandom_range(60, 70)) cyc();
      end else begin
        le = 6'd0;
        cyc();
      end
    end
    le = 6'd0;
    repeat (4) cyc();

`ifdef COLON_PERIOD_EN
    pv_seen = 0; last_period = 8'd0;
    colon_run(60, 3);
    check("colon_60_pulses", pv_seen, 2);
    check("colon_60_period", last_period, 8'd60);
    pv_seen = 0;
    colon_run(50, 3);
    check("colon_50_pulses", pv_seen, 3);
    check("colon_50_period", last_period, 8'd50);
`else
    colon_run(20, 3);
    check("colon_disabled_valid", period_valid, 1'b0);
    check("colon_disabled_period", colon_period, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_bus_decoder.md
Name: seg_bus_decoder

Overview:
- Receive-side counterpart of the clock chip's multiplexed display bus.
- Samples the 7-segment data bus (seg7 {a..g}), the six digit latch enables, PM and colon, then decodes each strobed digit to BCD.
- Assembles a complete HH:MM:SS frame, range-checks it, and publishes a 24h BCD time with a one-cycle valid pulse.
- Used in bench and in a loop-back self-test tile to check the display path end to end.

Parameters:
- FRAME_TIMEOUT, 64: clocks without any strobe after which a partial frame is discarded.
- PERIOD_W, 8: width of colon_period (optional feature only).

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg7  in  7  segment pattern {a,b,c,d,e,f,g}, active-high.
- le  in  6  latch enables: [0]=Ht, [1]=Ho, [2]=Mt, [3]=Mo, [4]=St, [5]=So.
- pm  in  1  PM flag from the display bus.
- colon  in  1  colon LED level.
- mode12  in  1  1 = bus carries 12h hours (01..12 + pm); 0 = 24h.
- hours_bcd  out  8  committed hours, 24h, packed BCD.
- min_bcd  out  8  committed minutes, packed BCD.
- sec_bcd  out  8  committed seconds, packed BCD.
- time_valid  out  1  one-cycle pulse when the outputs update.
- sec_tick  out  1  one-cycle pulse, coincident with time_valid, when sec_bcd changed value.
- seg_err  out  1  one-cycle pulse: invalid segment pattern or multiple-le collision.
- range_err  out  1  one-cycle pulse: completed frame failed the range check.
- timeout_err  out  1  one-cycle pulse: partial frame discarded.
- err_count  out  8  saturating count of all error pulses.
- colon_period  out  PERIOD_W  present only with COLON_PERIOD_EN.
- period_valid  out  1  present only with COLON_PERIOD_EN.

Behaviour:
- Reset: all outputs 0; shadow digits 0; mask 0; FSM in IDLE; timeout counter 0.
- Decode:
  - Recognised patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other pattern is invalid.
- Strobe handling, evaluated per clock:
  - le==0: no action.
  - Exactly one le bit set with a valid pattern: write that shadow digit, set its mask bit, reset timeout counter. A re-strobe of an already-set digit overwrites it (latest wins).
  - Exactly one le bit set with an invalid pattern: seg_err pulse; digit and mask unchanged.
  - More than one le bit set: seg_err pulse; strobe ignored.
- pm is sampled together with the Ho strobe.
- FSM states and transitions:
  - IDLE: mask==0. A valid strobe moves to COLLECT.
  - COLLECT:
    - When the mask reaches 6'b111111, go to COMMIT on the next edge.
    - If the timeout counter reaches FRAME_TIMEOUT-1 with no strobe: clear mask, timeout_err pulse, go to IDLE.
  - COMMIT (exactly one cycle):
    - Range check:
      - mode12=0: Ht≤2, Ho≤9, hour≤23.
      - mode12=1: hour in 01..12.
      - All modes: Mt≤5, St≤5.
    - Pass: register outputs and pulse time_valid.
    - Fail: range_err pulse; outputs hold.
    - Always: clear mask, go to IDLE.
    - A strobe sampled during COMMIT is accepted as the first digit of the next frame (mask becomes that bit only; FSM goes to COLLECT).
- Latency: the strobe that completes the frame is sampled at edge N; outputs and time_valid become visible after edge N+2.
- 12h→24h conversion:
  - 12 with pm=0 → 00.
  - 12 with pm=1 → 12.
  - h with pm=1, h=1..11 → h+12.
  - Otherwise unchanged.
- err_count: +1 per error pulse and saturates at 255. Simultaneous seg_err and timeout_err in the same cycle count as 2 (still saturating).
- Reset asserted mid-frame: immediate return to reset state; the partial frame is lost.

Optional Feature:
- Macro: COLON_PERIOD_EN.
- Enabled:
  - colon is synchronised with 2 flops, then edge-detected.
  - A PERIOD_W counter counts clocks between successive colon edges, saturating at all-ones.
  - On each edge after the first, colon_period is loaded with the count and period_valid pulses for one cycle.
  - Reset clears the counter and the "first edge seen" flag.
- Disabled: colon is unused; colon_period and period_valid are tied to 0.

Test Plan:
- Strobe Ht..So with patterns for 1,3,4,5,0,7, mode12=0 → time_valid 2 clocks after the So sample; hours_bcd=8'h13, min_bcd=8'h45, sec_bcd=8'h07; sec_tick=1.
- mode12=1, digits 1,2,0,0,0,0, pm=0 → hours_bcd=8'h00. Repeat with pm=1 → 8'h12. Digits 0,1 with pm=1 → 8'h13.
- Ht strobe with seg7=7'b0000001 → seg_err pulse, err_count=1, no time_valid. le=6'b000011 → seg_err, err_count=2.
- Frame with Mt=6 (1011111) → range_err pulse; outputs retain the previous frame.
- Strobe Ht and Ho only, then idle 64 clocks → timeout_err pulse on the 64th idle clock; FSM in IDLE; a following full frame commits normally.
- COLON_PERIOD_EN: toggle colon every 60 clocks → after the second edge, colon_period=60 with period_valid pulse. Toggle every 50 → colon_period=50.
